// File: rtl/easy_fifo_axis_out.sv
`default_nettype none
// ============================================================================
// easy_fifo_axis_out : FIFO read-side adapter driving an AXI-Stream master
// Revision: 1.0
// ============================================================================
module easy_fifo_axis_out #(
  parameter int DWIDTH     = 32,
  parameter int RD_LATENCY = 1,
  parameter int PKT_LEN    = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic                            rd_en,
  input  logic                            rd_empty,
  input  logic [DWIDTH-1:0]               rd_data,
  output logic [DWIDTH-1:0]               m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [$clog2(RD_LATENCY+2)-1:0] buf_level
);

  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int LVL_W     = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int MEM_N     = 1 << PTR_W;
  localparam int SUM_W     = LVL_W + 1;

  logic [DWIDTH-1:0] mem [MEM_N];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [LVL_W-1:0]  inflight;
  logic [SUM_W-1:0]  committed;
  logic              pop;
  logic              wr;
  logic              drain;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = mem[rd_ptr];
  assign buf_level     = count;
  assign drain         = m_axis_tvalid & m_axis_tready;
  assign pop           = rd_en & ~rd_empty;

  // A word leaving this cycle frees its slot in time for a pop issued now.
  always_comb begin
    committed = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(drain);
    rd_en     = rst_n & (committed < SUM_W'(BUF_DEPTH));
  end

  generate
    if (RD_LATENCY == 0) begin : g_fwft
      assign wr       = pop;
      assign inflight = '0;
    end else begin : g_pipe
      logic [RD_LATENCY-1:0] pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe <= '0;
        end else begin
          pipe <= (pipe << 1) | RD_LATENCY'(pop);
        end
      end

      assign wr = pipe[RD_LATENCY-1];

      always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
          inflight = inflight + LVL_W'(pipe[i]);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MEM_N; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr) begin
        mem[wr_ptr] <= rd_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (drain) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (wr && !drain) begin
        count <= count + LVL_W'(1);
      end else if (!wr && drain) begin
        count <= count - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(wr && !drain && count == LVL_W'(BUF_DEPTH)))
        else $error("easy_fifo_axis_out: skid buffer overflow");
    end
  end

  generate
    if (PKT_LEN > 0) begin : g_tlast
      logic [15:0] beat_cnt;

      assign m_axis_tlast = m_axis_tvalid && (beat_cnt == 16'(PKT_LEN - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          beat_cnt <= '0;
        end else if (drain) begin
          beat_cnt <= m_axis_tlast ? 16'd0 : beat_cnt + 16'd1;
        end
      end
    end else begin : g_no_tlast
      assign m_axis_tlast = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_easy_fifo_axis_out.sv
`default_nettype none
// ============================================================================
// tb_easy_fifo_axis_out : four adapters (RD_LATENCY 0..3) against FIFO models
// Revision: 1.0
// ============================================================================
module tb_easy_fifo_axis_out;

  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] fmem [N][8192];
  int            fwr [N];
  int            frd_pub [N];
  int            base [N];
  int            got [N];
  int            first_pop [N];
  int            first_valid [N];
  int            first_hs [N];
  int            last_hs [N];
  int            cyc;
  int            tests;
  int            fails;
  int            pushed;

  logic          rd_en [N];
  logic          rd_empty [N];
  logic [DW-1:0] rd_data [N];
  logic [DW-1:0] tdata [N];
  logic          tvalid [N];
  logic          tready [N];
  logic          tlast [N];
  logic [2:0]    lvl [N];

  // Instance k has RD_LATENCY=k; instance 1 also frames packets of 4.
  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int L  = k;
    localparam int LI = (L == 0) ? 0 : L - 1;
    localparam int LW = $clog2(L + 2);

    int            frd = 0;
    logic [DW-1:0] dl [4];
    logic [LW-1:0] lvl_l;

    always @(posedge clk) begin
      if (rd_en[k] && !rd_empty[k]) frd <= frd + 1;
      dl[0] <= fmem[k][frd];
      for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
    end

    assign rd_empty[k] = (fwr[k] == frd);
    assign rd_data[k]  = (L == 0) ? fmem[k][frd] : dl[LI];
    assign frd_pub[k]  = frd;
    assign lvl[k]      = 3'(lvl_l);

    easy_fifo_axis_out #(
      .DWIDTH(DW), .RD_LATENCY(L), .PKT_LEN((k == 1) ? 4 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .rd_en(rd_en[k]), .rd_empty(rd_empty[k]), .rd_data(rd_data[k]),
      .m_axis_tdata(tdata[k]), .m_axis_tvalid(tvalid[k]),
      .m_axis_tready(tready[k]), .m_axis_tlast(tlast[k]),
      .buf_level(lvl_l)
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [DW-1:0] d);
    fmem[k][fwr[k]] = d;
    fwr[k]++;
  endtask

  // Inputs are set just after a falling edge; this evaluates the coming rising edge.
  task automatic tick();
    int   infl;
    logic drain;
    #1;
    cyc++;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        infl  = (frd_pub[k] - base[k]) - got[k] - int'(lvl[k]);
        drain = tvalid[k] && tready[k];
        chk($sformatf("inflight_range[%0d]", k), (infl >= 0 && infl <= k), 1);
        chk($sformatf("level_max[%0d]", k), (int'(lvl[k]) <= k + 1), 1);
        chk($sformatf("tvalid_vs_level[%0d]", k), tvalid[k], (lvl[k] != 0));
        chk($sformatf("rd_en_credit[%0d]", k), rd_en[k],
            ((int'(lvl[k]) + infl - int'(drain)) < k + 1));
        if (tvalid[k])
          chk($sformatf("tdata_order[%0d]", k), tdata[k], fmem[k][base[k] + got[k]]);
        if (k == 1)
          chk("tlast[1]", tlast[k], (tvalid[k] && (got[k] % 4 == 3)));
        else
          chk($sformatf("tlast_low[%0d]", k), tlast[k], 0);
        if (rd_en[k] && !rd_empty[k] && first_pop[k] < 0) first_pop[k] = cyc;
        if (tvalid[k] && first_valid[k] < 0) first_valid[k] = cyc;
        if (drain) begin
          if (first_hs[k] < 0) first_hs[k] = cyc;
          last_hs[k] = cyc;
          got[k]++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    cyc    = 0;
    pushed = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < N; k++) begin
      fwr[k] = 0; base[k] = 0; got[k] = 0; tready[k] = 1'b1;
      first_pop[k] = -1; first_valid[k] = -1; first_hs[k] = -1; last_hs[k] = -1;
    end

    // Preloaded FIFO, full-rate drain at latency 1
    for (int i = 0; i < 16; i++) push(1, DW'(32'h10 + i));
    @(negedge clk);
    repeat (2) tick();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset_rd_en[%0d]", k), rd_en[k], 0);
      chk($sformatf("reset_tvalid[%0d]", k), tvalid[k], 0);
      chk($sformatf("reset_tlast[%0d]", k), tlast[k], 0);
      chk($sformatf("reset_tdata[%0d]", k), tdata[k], 0);
      chk($sformatf("reset_level[%0d]", k), lvl[k], 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50 && got[1] < 16; i++) tick();
    chk("t1_count", got[1], 16);
    chk("t1_latency", first_valid[1] - first_pop[1], 2);
    chk("t1_no_gaps", last_hs[1] - first_hs[1], 15);

    // Packet framing continues across bursts
    for (int i = 0; i < 10; i++) push(1, DW'($urandom));
    for (int i = 0; i < 60 && got[1] < 26; i++) tick();
    chk("t4_count", got[1], 26);
    for (int i = 0; i < 3; i++) push(1, DW'($urandom));
    for (int i = 0; i < 40 && got[1] < 29; i++) tick();
    chk("t4_resume_count", got[1], 29);

    // Fall-through FIFO, single word held under backpressure
    tready[0] = 1'b0;
    push(0, DW'(32'hA5));
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", tvalid[0], 1);
      chk("t3_hold_data", tdata[0], 32'hA5);
      tick();
    end
    tready[0] = 1'b1;
    tick();
    tick();
    chk("t3_single_beat", got[0], 1);
    chk("t3_valid_low", tvalid[0], 0);
    chk("t3_level_zero", lvl[0], 0);
    chk("t3_latency", first_valid[0] - first_pop[0], 1);

    // Latency 2 with a 1,0,0,1 ready pattern
    for (int i = 0; i < 40; i++) push(2, DW'($urandom));
    for (int i = 0; i < 400 && got[2] < 40; i++) begin
      tready[2] = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    chk("t2_count", got[2], 40);

    // Asynchronous reset with two words buffered and one in flight
    tready[2] = 1'b0;
    for (int i = 0; i < 6; i++) push(2, DW'($urandom));
    for (int i = 0; i < 20 && lvl[2] != 2; i++) tick();
    chk("t5_level_before", lvl[2], 2);
    chk("t5_inflight_before", (frd_pub[2] - base[2]) - got[2] - int'(lvl[2]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rd_en_async", rd_en[2], 0);
    chk("t5_tvalid_async", tvalid[2], 0);
    chk("t5_tlast_async", tlast[2], 0);
    chk("t5_level_async", lvl[2], 0);
    for (int k = 0; k < N; k++) begin
      base[k] = frd_pub[k];
      got[k]  = 0;
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tready[2] = 1'b1;
    for (int i = 0; i < 5; i++) push(2, DW'($urandom));
    for (int i = 0; i < 60 && got[2] < 8; i++) tick();
    chk("t5_after_reset_count", got[2], 8);

    // Latency 3, random ready and bursty FIFO fill
    for (int i = 0; i < 40000 && got[3] < 5000; i++) begin
      tready[3] = 1'($urandom_range(0, 1));
      if (pushed < 5000 && $urandom_range(0, 99) < ((((i / 64) % 2) == 1) ? 90 : 20)) begin
        push(3, DW'($urandom));
        pushed++;
      end
      tick();
    end
    chk("t6_count", got[3], 5000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
